// File: rtl/status_cond_unit.sv
// Status-flag condition evaluator: req/ack, defers while flags load; optional counters under STATUS_COND_STATS_EN.
// Latency: ack one cycle after accept plus one per load-wait cycle; req is only taken in IDLE.
module status_cond_unit #(
  parameter int WAIT_LIMIT  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic [2:0]             cond,
  input  logic                   notLoadStatus,
  input  logic                   cFlag,
  input  logic                   zFlag,
  output logic                   busy,
  output logic                   ack,
  output logic                   taken,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] evalCount,
  output logic [COUNT_WIDTH-1:0] takenCount
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EVAL, S_DONE, S_FAULT} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

  state_t     state;
  logic [2:0] cond_reg;
  logic [3:0] wait_cnt;

  function automatic logic cond_true(input logic [2:0] code, input logic c, input logic z);
    case (code)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = c;
      3'd2:    cond_true = ~c;
      3'd3:    cond_true = z;
      3'd4:    cond_true = ~z;
      3'd5:    cond_true = c | z;
      3'd6:    cond_true = ~c & ~z;
      default: cond_true = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      ack      <= 1'b0;
      taken    <= 1'b0;
      timeout  <= 1'b0;
      cond_reg <= 3'd0;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            cond_reg <= cond;
            busy     <= 1'b1;
            timeout  <= 1'b0;
            wait_cnt <= 4'd0;
            state    <= notLoadStatus ? S_EVAL : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!notLoadStatus) begin
            if (wait_cnt == WAIT_LAST) begin
              taken   <= 1'b0;
              timeout <= 1'b1;
              state   <= S_FAULT;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end else begin
            state <= S_EVAL;
          end
        end
        // A load starting on this edge still leaves the pre-write flags on the bus.
        S_EVAL: begin
          taken <= cond_true(cond_reg, cFlag, zFlag);
          ack   <= 1'b1;
          state <= S_DONE;
        end
        S_FAULT: begin
          ack   <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STATUS_COND_STATS_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] eval_cnt;
  logic [COUNT_WIDTH-1:0] taken_cnt;
  logic                   completing;
  logic                   completing_taken;

  // Counters move on the same edge that raises ack, so they track ack exactly.
  assign completing       = (state == S_EVAL) || (state == S_FAULT);
  assign completing_taken = (state == S_EVAL) && cond_true(cond_reg, cFlag, zFlag);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else begin
      if (completing && (eval_cnt != '1))
        eval_cnt <= eval_cnt + CNT_ONE;
      if (completing_taken && (taken_cnt != '1))
        taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

  assign evalCount  = eval_cnt;
  assign takenCount = taken_cnt;
`else
  assign evalCount  = '0;
  assign takenCount = '0;
`endif

endmodule

// File: tb/tb_status_cond_unit.sv
// Self-checking bench for status_cond_unit: directed and randomized evaluations against a table model.
// A second instance with 2-bit counters sees identical stimulus to cover counter saturation.
module tb_status_cond_unit;
  localparam int WL = 4;

  logic       clock = 1'b0;
  logic       clk_run = 1'b1;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [2:0] cond = 3'd0;
  logic       notLoadStatus = 1'b1;
  logic       cFlag = 1'b0;
  logic       zFlag = 1'b0;

  logic        busy, ack, taken, timeout;
  logic [15:0] evalCount, takenCount;
  logic        s_busy, s_ack, s_taken, s_timeout;
  logic [1:0]  s_evalCount, s_takenCount;

  int tests = 0;
  int fails = 0;
  int exp_eval = 0;
  int exp_taken = 0;

  status_cond_unit #(.WAIT_LIMIT(WL), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .req(req), .cond(cond), .notLoadStatus(notLoadStatus),
    .cFlag(cFlag), .zFlag(zFlag), .busy(busy), .ack(ack), .taken(taken), .timeout(timeout),
    .evalCount(evalCount), .takenCount(takenCount)
  );

  status_cond_unit #(.WAIT_LIMIT(WL), .COUNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .req(req), .cond(cond), .notLoadStatus(notLoadStatus),
    .cFlag(cFlag), .zFlag(zFlag), .busy(s_busy), .ack(s_ack), .taken(s_taken), .timeout(s_timeout),
    .evalCount(s_evalCount), .takenCount(s_takenCount)
  );

  always #5 if (clk_run) clock = ~clock;

  function automatic logic ref_taken(input int c, input logic cf, input logic zf);
    case (c)
      0: return 1'b1;
      1: return cf;
      2: return !cf;
      3: return zf;
      4: return !zf;
      5: return cf || zf;
      6: return !cf && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both instances must agree with the same expected bit.
  task automatic chk_out(input string tag, input logic b, input logic s, input logic e);
    chk(tag, {30'd0, b, s}, {30'd0, e, e});
  endtask

  task automatic chk_counts(input string tag);
    int ee, et;
`ifdef STATUS_COND_STATS_EN
    ee = exp_eval;
    et = exp_taken;
`else
    ee = 0;
    et = 0;
`endif
    chk({tag, "_evalCount"}, 32'(evalCount), ee);
    chk({tag, "_takenCount"}, 32'(takenCount), et);
    chk({tag, "_sat_evalCount"}, 32'(s_evalCount), sat3(ee));
    chk({tag, "_sat_takenCount"}, 32'(s_takenCount), sat3(et));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // w = number of consecutive edges, starting with the accept edge, on which a flag load is in progress.
  task automatic run_txn(input int c, input logic cf, input logic zf, input int w, input string tag);
    int   k_ack;
    logic exp_to, exp_tk;
    k_ack  = 1 + ((w < WL) ? w : WL);
    exp_to = (w > WL);
    exp_tk = exp_to ? 1'b0 : ref_taken(c, cf, zf);
    req           = 1'b1;
    cond          = 3'(c);
    notLoadStatus = (w == 0);
    cFlag         = (w == 0) ? cf : !cf;
    zFlag         = (w == 0) ? zf : !zf;
    step();
    req  = 1'b0;
    cond = 3'($urandom);
    chk_out({tag, "_accept_busy"}, busy, s_busy, 1'b1);
    chk_out({tag, "_accept_ack"}, ack, s_ack, 1'b0);
    chk_out({tag, "_accept_timeout"}, timeout, s_timeout, 1'b0);
    for (int k = 1; k <= k_ack + 1; k++) begin
      if (k < w) begin
        notLoadStatus = 1'b0;
        cFlag = !cf;
        zFlag = !zf;
      end else begin
        notLoadStatus = 1'b1;
        cFlag = cf;
        zFlag = zf;
      end
      step();
      if (k == k_ack) begin
        exp_eval++;
        if (exp_tk) exp_taken++;
        chk_out({tag, "_ack"}, ack, s_ack, 1'b1);
        chk_out({tag, "_taken"}, taken, s_taken, exp_tk);
        chk_out({tag, "_timeout"}, timeout, s_timeout, exp_to);
        chk_out({tag, "_busy_at_ack"}, busy, s_busy, 1'b1);
        chk_counts(tag);
      end else if (k < k_ack) begin
        chk_out({tag, "_early_ack"}, ack, s_ack, 1'b0);
        chk_out({tag, "_busy_pending"}, busy, s_busy, 1'b1);
      end else begin
        chk_out({tag, "_ack_drop"}, ack, s_ack, 1'b0);
        chk_out({tag, "_busy_drop"}, busy, s_busy, 1'b0);
        chk_out({tag, "_taken_hold"}, taken, s_taken, exp_tk);
        chk_out({tag, "_timeout_hold"}, timeout, s_timeout, exp_to);
      end
    end
  endtask

  initial begin
    int acks;
    #1 reset = 1'b1;
    #2;
    chk_out("reset_busy", busy, s_busy, 1'b0);
    chk_out("reset_ack", ack, s_ack, 1'b0);
    chk_out("reset_taken", taken, s_taken, 1'b0);
    chk_out("reset_timeout", timeout, s_timeout, 1'b0);
    chk_counts("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++)
        run_txn(c, f[1], f[0], 0, "table");
    chk_counts("table_total");

    run_txn(1, 1'b1, 1'b0, 2, "pending");
    run_txn(0, 1'b1, 1'b1, WL + 2, "timeout");
    run_txn(3, 1'b0, 1'b1, 0, "after_timeout");

    // Held req: accepts at edges 0,3,6; cond is scrambled while busy.
    req = 1'b1;
    cond = 3'd0;
    notLoadStatus = 1'b1;
    acks = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      cond = (((k + 1) % 3) == 0) ? 3'd0 : 3'd7;
      chk_out("b2b_ack", ack, s_ack, (k % 3) == 1);
      if (ack) begin
        acks++;
        chk_out("b2b_taken", taken, s_taken, 1'b1);
      end
    end
    req = 1'b0;
    exp_eval += 3;
    exp_taken += 3;
    chk("b2b_ack_count", acks, 3);
    step();
    chk_out("b2b_idle", busy, s_busy, 1'b0);
    chk_counts("b2b");

    for (int i = 0; i < 40; i++)
      run_txn(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 6)), "rand");

    // Abort in WAIT with the clock frozen.
    req = 1'b1;
    cond = 3'd0;
    notLoadStatus = 1'b0;
    step();
    req = 1'b0;
    step();
    chk_out("abort_busy_before", busy, s_busy, 1'b1);
    clk_run = 1'b0;
    #7 reset = 1'b1;
    #1;
    exp_eval = 0;
    exp_taken = 0;
    chk_out("abort_busy", busy, s_busy, 1'b0);
    chk_out("abort_ack", ack, s_ack, 1'b0);
    chk_out("abort_taken", taken, s_taken, 1'b0);
    chk_out("abort_timeout", timeout, s_timeout, 1'b0);
    chk_counts("abort");
    #3 reset = 1'b0;
    clk_run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_out("abort_no_ack", ack, s_ack, 1'b0);
      chk_out("abort_idle", busy, s_busy, 1'b0);
    end

    for (int i = 0; i < 5; i++)
      run_txn(0, 1'($urandom), 1'($urandom), 0, "sat");
    chk_counts("sat_total");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Read side of the status register: samples the carry and zero flag outputs and evaluates a 3-bit condition code for conditional jump/move instructions.
- Sits between the statusRegister outputs and the control sequencer.
- Uses a req/ack handshake and waits while the status register is being loaded, so the sequencer never evaluates a flag that is still being written.

Parameters:
- WAIT_LIMIT, 4: maximum cycles spent in WAIT before a timeout fault; legal range 1..15.
- COUNT_WIDTH, 16: width of the statistics counters (see Optional Feature).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  start an evaluation; sampled only in IDLE.
- cond  input  3  condition code; captured together with an accepted req.
- notLoadStatus  input  1  mirror of the status register's active-low load strobe; 0 means the flags are being written this cycle.
- cFlag  input  1  carry flag from the status register output.
- zFlag  input  1  zero flag from the status register output.
- busy  output  1  high from the accepting edge until the return to IDLE.
- ack  output  1  one-cycle completion pulse.
- taken  output  1  condition result; valid while ack=1 and held until the next accepted req.
- timeout  output  1  sticky fault flag; cleared by the next accepted req.
- evalCount  output  COUNT_WIDTH  number of evaluations completed.
- takenCount  output  COUNT_WIDTH  number of evaluations with taken=1.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - busy, ack, taken and timeout all 0.
  - Both counters 0; internal condReg and waitCnt 0.
- Condition encoding:
  - 0 always (1); 1 C; 2 !C; 3 Z; 4 !Z.
  - 5 C|Z; 6 !C&!Z; 7 never (0).
- States: IDLE, WAIT, EVAL, DONE, FAULT. All outputs are registered.
- IDLE:
  - On an edge with req=1: condReg<=cond, busy<=1, timeout<=0.
  - If notLoadStatus=0 at that edge: next state is WAIT with waitCnt<=0. Otherwise next state is EVAL.
- WAIT:
  - On each edge with notLoadStatus=0: if waitCnt=WAIT_LIMIT-1, go to FAULT; else waitCnt++.
  - On an edge with notLoadStatus=1: go to EVAL.
- EVAL:
  - On the edge: taken<=f(condReg, cFlag, zFlag), ack<=1, go to DONE.
  - If notLoadStatus=0 at this edge, flags are still sampled (the load began after settle). The result uses the pre-write flags.
- DONE:
  - On the edge: ack<=0, busy<=0, go to IDLE.
  - ack is therefore high for exactly one cycle.
- FAULT:
  - Entered with taken<=0 and timeout<=1.
  - On the next edge: ack<=1, then DONE behaviour. So ack pulses once with taken=0 and timeout=1.
- Latency: req accepted at edge N with stable flags gives ack high from edge N+1 to edge N+2. Each wait cycle adds one cycle.
- Handshake:
  - req is ignored unless state=IDLE.
  - req held high gives back-to-back evaluations: one accept every 3 cycles with stable flags.
  - cond changes after acceptance have no effect.
- Reset mid-operation: everything returns to its reset values immediately. No ack is issued for the aborted request.
- Counters:
  - evalCount increments at every ack pulse, including FAULT.
  - takenCount increments when ack is asserted with taken=1.
  - Both saturate at all-ones and do not wrap.

Optional Feature:
- Macro: STATUS_COND_STATS_EN.
- Defined: evalCount and takenCount behave as specified above.
- Undefined: the counter registers are not built; evalCount and takenCount are tied to 0. Port list and all other behaviour are unchanged.

Test Plan:
- Reset: assert reset mid-cycle with clock stopped → busy=0, ack=0, taken=0, timeout=0 and counters 0 immediately.
- All codes with flags stable: for each cond 0..7 against {C,Z} in {00,01,10,11} → taken matches the encoding table, ack is a single cycle 1 edge after accept, and evalCount=32 at the end (with STATUS_COND_STATS_EN).
- Pending flag write: notLoadStatus=0 for 2 cycles at accept, with flags changing C=0→1 during the write, cond=1 → ack arrives 3 cycles after accept and taken=1.
- Timeout: WAIT_LIMIT=4, notLoadStatus held 0 → ack pulses with taken=0 and timeout=1. The next req with notLoadStatus=1 clears timeout.
- Back-to-back and ignored req: req held high for 9 cycles with cond=0 → exactly 3 acks, and a cond change while busy is ignored.
- Saturation and reset mid-op: with COUNT_WIDTH=2, 5 taken evaluations → evalCount=takenCount=3. Then reset while in WAIT → no ack, and all outputs return to 0.
